// File: rtl/gradient_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gradient_pkg
//  Description : Shared types for the gradient window sequencer: the 8-bit
//                pixel type, the sequencer state encoding and the legal
//                image-dimension range.
//  Revision    : 1.0 - initial release
// ============================================================================
package gradient_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    localparam int c_MIN_DIM = 3;
    localparam int c_MAX_DIM = 1024;

    // A 3x3 window needs at least three rows/columns; 1024 bounds the counters.
    function automatic logic dim_ok(input int d);
        return (d >= c_MIN_DIM) && (d <= c_MAX_DIM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer
//  Description : One image row of pixels held in a register array with one
//                write port and one asynchronous read port. Contents are not
//                reset; the sequencer always rewrites a row before using it.
//  Ports       : clk      - rising-edge clock
//                i_we     - write enable
//                i_waddr  - write column
//                i_wdata  - write pixel
//                i_raddr  - read column
//                o_rdata  - pixel stored at i_raddr
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer
    import gradient_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  pixel_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output pixel_t        o_rdata
);

    pixel_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read-before-write: the sequencer reads the old entry in the same cycle
    // it overwrites it.
    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/gradient_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gradient_window_sequencer
//  Description : Accepts a raster-order 8-bit frame and emits, for every
//                interior pixel, the up/left/centre/right/down neighbours
//                (a 3x3 cross) for a downstream gradient stage.
//  Ports       : clk, n_rst         - clock, async active-low reset
//                start              - frame start request (IDLE only)
//                pix_in/valid/ready - pixel input handshake
//                win_p2/p4/p5/p6/p8 - window taps (up/left/centre/right/down)
//                win_valid/ready    - window output handshake
//                frame_done         - one-cycle end-of-frame pulse
//                win_count          - windows handed off this frame (optional)
//  Options     : GRADIENT_WIN_COUNT_EN - adds the 16-bit saturating win_count
//                output.
//  Revision    : 1.0 - initial release
// ============================================================================
module gradient_window_sequencer
    import gradient_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  win_p2,
    output logic [7:0]  win_p4,
    output logic [7:0]  win_p5,
    output logic [7:0]  win_p6,
    output logic [7:0]  win_p8,
    output logic        win_valid,
    input  logic        win_ready,
`ifdef GRADIENT_WIN_COUNT_EN
    output logic [15:0] win_count,
`endif
    output logic        frame_done
);

    localparam int c_CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [c_CW-1:0] c_LAST_COL = c_CW'(IMG_W - 1);
    localparam logic [c_RW-1:0] c_LAST_ROW = c_RW'(IMG_H - 1);
    localparam logic [c_CW-1:0] c_COL_TWO  = c_CW'(2);
    localparam logic [c_RW-1:0] c_ROW_TWO  = c_RW'(2);

    generate
        if (!dim_ok(IMG_W)) begin : g_bad_img_w
            $error("gradient_window_sequencer: IMG_W must be within 3..1024");
        end
        if (!dim_ok(IMG_H)) begin : g_bad_img_h
            $error("gradient_window_sequencer: IMG_H must be within 3..1024");
        end
    endgenerate

    seq_state_t      r_state;
    logic [c_CW-1:0] r_col;
    logic [c_RW-1:0] r_row;

    // Previous column (c-1) of the window and the centre row of column c-2.
    pixel_t r_top1;
    pixel_t r_mid1;
    pixel_t r_bot1;
    pixel_t r_mid2;

    pixel_t w_lb1_rd;   // row r-1 at the current column
    pixel_t w_lb2_rd;   // row r-2 at the current column
    logic   w_accept;
    logic   w_produce;
    logic   w_last;

    assign pix_ready = ((r_state == FILL) || (r_state == STREAM)) &&
                       (!win_valid || win_ready);
    assign w_accept  = pix_valid && pix_ready;
    assign w_last    = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);
    // Requiring c>=2 keeps every window inside one row.
    assign w_produce = w_accept && (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);

    // Row r-1 buffer: new pixel replaces the entry that moves down to r-2.
    line_buffer #(
        .DEPTH (IMG_W),
        .AW    (c_CW)
    ) u_lb_prev1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_col),
        .i_wdata (pix_in),
        .i_raddr (r_col),
        .o_rdata (w_lb1_rd)
    );

    line_buffer #(
        .DEPTH (IMG_W),
        .AW    (c_CW)
    ) u_lb_prev2 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_col),
        .i_wdata (w_lb1_rd),
        .i_raddr (r_col),
        .o_rdata (w_lb2_rd)
    );

    // Sequencer state, raster counters and end-of-frame pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_col      <= '0;
            r_row      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (w_accept) begin
                if (r_col == c_LAST_COL) begin
                    r_col <= '0;
                    r_row <= (r_row == c_LAST_ROW) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FILL;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                FILL: begin
                    if (w_accept && w_last) begin
                        r_state <= DRAIN;
                    end else if (w_accept && (r_row == c_ROW_TWO)) begin
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_accept && w_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!win_valid || win_ready) begin
                        r_state    <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Column shift window and registered taps.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win_valid <= 1'b0;
            win_p2    <= '0;
            win_p4    <= '0;
            win_p5    <= '0;
            win_p6    <= '0;
            win_p8    <= '0;
            r_top1    <= '0;
            r_mid1    <= '0;
            r_bot1    <= '0;
            r_mid2    <= '0;
        end else begin
            // pix_ready already blocks acceptance while a window is stalled,
            // so a new window never overwrites an unaccepted one.
            if (w_produce) begin
                win_valid <= 1'b1;
                win_p2    <= r_top1;
                win_p4    <= r_mid2;
                win_p5    <= r_mid1;
                win_p6    <= w_lb1_rd;
                win_p8    <= r_bot1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end

            if (w_accept) begin
                r_mid2 <= r_mid1;
                r_top1 <= w_lb2_rd;
                r_mid1 <= w_lb1_rd;
                r_bot1 <= pix_in;
            end
        end
    end

`ifdef GRADIENT_WIN_COUNT_EN
    logic [15:0] r_win_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_win_count <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_win_count <= '0;
        end else if (win_valid && win_ready && (r_win_count != 16'hFFFF)) begin
            r_win_count <= r_win_count + 16'd1;
        end
    end

    assign win_count = r_win_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gradient_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gradient_window_sequencer
//  Description : Self-checking bench. A 4x4 and a 16x16 instance share the
//                stimulus; sel routes start/pix_valid to one instance and
//                muxes its outputs back. Expected windows are computed from
//                the stored image on each pixel acceptance and queued, then
//                compared on each window handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gradient_window_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst;
    logic       start;
    logic       pix_valid;
    logic       win_ready;
    logic       sel;          // 0: 4x4 instance, 1: 16x16 instance
    logic [7:0] pix_in;

    logic start4, start16, pv4, pv16;
    logic pr4, pr16, wv4, wv16, fd4, fd16;
    logic [4:0][7:0] t4, t16, taps;   // [0]=p2 [1]=p4 [2]=p5 [3]=p6 [4]=p8
    logic pix_ready_m, win_valid_m, frame_done_m;
`ifdef GRADIENT_WIN_COUNT_EN
    logic [15:0] wc4, wc16;
`endif

    assign start4       = start & ~sel;
    assign start16      = start & sel;
    assign pv4          = pix_valid & ~sel;
    assign pv16         = pix_valid & sel;
    assign pix_ready_m  = sel ? pr16 : pr4;
    assign win_valid_m  = sel ? wv16 : wv4;
    assign frame_done_m = sel ? fd16 : fd4;
    assign taps         = sel ? t16 : t4;

    gradient_window_sequencer #(.IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start4),
        .pix_in     (pix_in),
        .pix_valid  (pv4),
        .pix_ready  (pr4),
        .win_p2     (t4[0]),
        .win_p4     (t4[1]),
        .win_p5     (t4[2]),
        .win_p6     (t4[3]),
        .win_p8     (t4[4]),
        .win_valid  (wv4),
        .win_ready  (win_ready),
`ifdef GRADIENT_WIN_COUNT_EN
        .win_count  (wc4),
`endif
        .frame_done (fd4)
    );

    gradient_window_sequencer #(.IMG_W(16), .IMG_H(16)) u_dut16 (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start16),
        .pix_in     (pix_in),
        .pix_valid  (pv16),
        .pix_ready  (pr16),
        .win_p2     (t16[0]),
        .win_p4     (t16[1]),
        .win_p5     (t16[2]),
        .win_p6     (t16[3]),
        .win_p8     (t16[4]),
        .win_valid  (wv16),
        .win_ready  (win_ready),
`ifdef GRADIENT_WIN_COUNT_EN
        .win_count  (wc16),
`endif
        .frame_done (fd16)
    );

    int checks = 0;
    int errors = 0;
    int img_w  = 4;
    int img_h  = 4;
    logic [7:0] img [256];
    logic [4:0][7:0] exp_q [$];

    task automatic load_image(input bit big);
        sel   = big;
        img_w = big ? 16 : 4;
        img_h = big ? 16 : 4;
        for (int i = 0; i < img_w * img_h; i++) begin
            img[i] = big ? 8'($urandom_range(0, 255)) : 8'(i);   // 4x4: 4r+c
        end
    endtask

    // mode 0: win_ready always 1; 1: stall first window 5 cycles;
    // 2: random pix_valid and win_ready gaps. start_at >= 0 re-pulses start
    // once when that many pixels have been accepted.
    task automatic run_frame(input int mode, input int start_at, input int exp_windows);
        int n;
        int k;
        int windows;
        int done_cnt;
        int cyc;
        int stall;
        int tail;
        int r;
        int c;
        bit pend_lat;
        bit prev_stall;
        bit start_pulsed;
        logic [4:0][7:0] prev_taps;
        logic [4:0][7:0] e;
        n = img_w * img_h;
        k = 0; windows = 0; done_cnt = 0; cyc = 0; stall = 0; tail = 0;
        pend_lat = 0; prev_stall = 0; start_pulsed = 0; prev_taps = '0;
        exp_q.delete();

        @(posedge clk); #1;
        start = 1'b1; pix_valid = 1'b0; win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; pix_valid = 1'b1; pix_in = img[0];

        while (cyc < 5000) begin
            @(negedge clk);
            if (pend_lat) begin
                checks++;
                if (win_valid_m !== 1'b1) begin
                    errors++;
                    $display("FAIL latency: win_valid=%b required 1 after window-producing pixel", win_valid_m);
                end
                pend_lat = 0;
            end
            if (prev_stall) begin
                checks++;
                if (win_valid_m !== 1'b1 || taps !== prev_taps) begin
                    errors++;
                    $display("FAIL hold: valid=%b taps=%h required valid=1 taps=%h", win_valid_m, taps, prev_taps);
                end
            end
            if (win_valid_m && !win_ready) begin
                checks++;
                if (pix_ready_m !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: pix_ready=%b required 0", pix_ready_m);
                end
            end
            prev_stall = win_valid_m && !win_ready;
            prev_taps  = taps;
            if (frame_done_m === 1'b1) done_cnt++;

            if (pix_valid && pix_ready_m) begin
                r = k / img_w;
                c = k % img_w;
                if (r >= 2 && c >= 2) begin
                    e[0] = img[(r - 2) * img_w + c - 1];
                    e[1] = img[(r - 1) * img_w + c - 2];
                    e[2] = img[(r - 1) * img_w + c - 1];
                    e[3] = img[(r - 1) * img_w + c];
                    e[4] = img[r * img_w + c - 1];
                    exp_q.push_back(e);
                    pend_lat = 1;
                end
                k++;
            end
            if (win_valid_m && win_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_window: taps=%h required no window", taps);
                end else begin
                    e = exp_q.pop_front();
                    windows++;
                    if (taps !== e) begin
                        errors++;
                        $display("FAIL taps window %0d: got %h required %h", windows, taps, e);
                    end
                end
            end
            if (done_cnt > 0 && k == n) tail++;
            if (tail >= 4) break;

            @(posedge clk); #1;
            cyc++;
            pix_valid = (k < n) && ((mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1);
            pix_in    = (k < n) ? img[k] : 8'h00;
            if (mode == 1) begin
                if (win_valid_m && stall < 5) begin
                    win_ready = 1'b0;
                    stall++;
                end else begin
                    win_ready = 1'b1;
                end
            end else if (mode == 2) begin
                win_ready = ($urandom_range(0, 2) != 0);
            end else begin
                win_ready = 1'b1;
            end
            start = (start_at >= 0) && (k == start_at) && !start_pulsed;
            if (start) start_pulsed = 1;
        end
        pix_valid = 1'b0; start = 1'b0; win_ready = 1'b1;

        checks++;
        if (tail < 4) begin
            errors++;
            $display("FAIL timeout: frame incomplete, pixels=%0d required %0d", k, n);
        end
        checks++;
        if (windows != exp_windows) begin
            errors++;
            $display("FAIL window_count: got %0d required %0d", windows, exp_windows);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL frame_done_pulses: got %0d required 1", done_cnt);
        end
        checks++;
        if (pix_ready_m !== 1'b0 || win_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_frame: pix_ready=%b win_valid=%b required 0 0", pix_ready_m, win_valid_m);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (pix_ready_m !== 1'b0 || win_valid_m !== 1'b0 || frame_done_m !== 1'b0 || taps !== '0) begin
            errors++;
            $display("FAIL %s: pix_ready=%b win_valid=%b frame_done=%b taps=%h required all 0",
                     tag, pix_ready_m, win_valid_m, frame_done_m, taps);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b0; pix_valid = 1'b0; win_ready = 1'b1; pix_in = '0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_4x4");
        sel = 1'b1; #1;
        check_outputs_zero("reset_16x16");
        sel = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        // Without start, pixels must not be accepted.
        pix_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pix_ready_m !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: pix_ready=%b required 0", pix_ready_m);
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_basic();
        load_image(1'b0);
        run_frame(0, -1, 4);
`ifdef GRADIENT_WIN_COUNT_EN
        checks++;
        if (wc4 !== 16'd4) begin
            errors++;
            $display("FAIL win_count_basic: got %0d required 4", wc4);
        end
`endif
    endtask

    task automatic test_stall();
        load_image(1'b0);
        run_frame(1, -1, 4);
    endtask

    task automatic test_start_ignored();
        load_image(1'b0);
        run_frame(0, 9, 4);
`ifdef GRADIENT_WIN_COUNT_EN
        checks++;
        if (wc4 !== 16'd4) begin
            errors++;
            $display("FAIL win_count_start: got %0d required 4", wc4);
        end
`endif
    endtask

    task automatic test_random_16x16();
        load_image(1'b1);
        run_frame(2, -1, 196);
    endtask

    task automatic test_midframe_reset();
        int k;
        int guard;
        load_image(1'b0);
        k = 0; guard = 0;
        @(posedge clk); #1;
        start = 1'b1; win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (k < 9 && guard < 100) begin
            pix_valid = 1'b1;
            pix_in    = img[k];
            @(negedge clk);
            if (pix_ready_m) k++;
            @(posedge clk); #1;
            guard++;
        end
        pix_valid = 1'b0;
        #1 n_rst = 1'b0;
        #1;
        check_outputs_zero("midframe_reset");
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_ready_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: pix_ready=%b required 0", pix_ready_m);
        end
        run_frame(0, -1, 4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_random_16x16();
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
